// File: rtl/bcd_disp_pkg.sv
// Shared types and active-high 7-segment patterns for the BCD display scanner.
package bcd_disp_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Segment order is {g,f,e,d,c,b,a}; all patterns are active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  bcd_digit_t  digit,
  output logic [6:0]  seg,
  output logic        invalid
);

  always_comb begin
    // NOTE: default every output first so no path through the case infers a latch.
    seg     = SEG_DASH;
    invalid = !bcd_valid(digit);
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with a per-scan snapshot of the BCD word.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    digit_err
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (COMMON_ANODE != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (COMMON_ANODE != 0) ? '1 : '0;

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snapshot;
  logic                    snap_pending;
  logic                    tick;
  logic                    wrap;

  assign tick = enable && (prescaler == PRE_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prescaler    <= '0;
      idx          <= '0;
      snapshot     <= '0;
      snap_pending <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (enable) prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick)   idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (snap_pending || wrap) snapshot <= bcd_in;
      snap_pending <= 1'b0;
    end
  end

  // The word being loaded this edge is shown straight away, so the first
  // digit after reset is never the stale all-zero snapshot.
  logic [4*NUM_DIGITS-1:0] src_word;
  bcd_digit_t              digits [NUM_DIGITS];
  bcd_digit_t              cur_digit;

  assign src_word = snap_pending ? bcd_in : snapshot;

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) digits[k] = src_word[4*k +: 4];
  end

  assign cur_digit = digits[idx];

  logic [6:0] dec_seg;
  logic       dec_invalid;

  bcd_to_7seg u_dec (
    .digit   (cur_digit),
    .seg     (dec_seg),
    .invalid (dec_invalid)
  );

  logic lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_nonzero;

  always_comb begin
    upper_nonzero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && digits[k] != 4'd0) upper_nonzero = 1'b1;
    end
    lz_blank = (idx != '0) && !upper_nonzero;
  end
`else
  assign lz_blank = 1'b0;
`endif

  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  err_next;

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    err_next = 1'b0;
    if (enable && !lz_blank) begin
      an_next  = AN_OFF ^ (NUM_DIGITS'(1) << idx);
      seg_next = SEG_OFF ^ dec_seg;
      err_next = dec_invalid;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      seg       <= SEG_OFF;
      an        <= AN_OFF;
      digit_err <= 1'b0;
    end else begin
      seg       <= seg_next;
      an        <= an_next;
      digit_err <= err_next;
    end
  end

endmodule
